// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared constants, state encoding and frame helpers for mult_sched
package mult_sched_pkg;

  localparam int FRAME_BITS = 32;
  localparam int LEN_BITS   = 8;
  localparam int OPND_BITS  = 24;
  localparam int MAX_LEN    = 23;

  // One-hot so each state decode is a single flop bit.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_START = 5'b00010,
    ST_SHIFT = 5'b00100,
    ST_WAIT  = 5'b01000,
    ST_RESP  = 5'b10000
  } state_t;

  // Multiplier length must leave at least one multiplicand bit and use at least one bit.
  function automatic logic len_legal(input logic [LEN_BITS-1:0] len);
    return (len != '0) && (len <= LEN_BITS'(MAX_LEN));
  endfunction

  // Frame as sent LSB first: length byte, then L multiplier bits, then 24-L multiplicand bits.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [LEN_BITS-1:0]  len,
                                                        input logic [OPND_BITS-1:0] a,
                                                        input logic [OPND_BITS-1:0] b);
    logic [OPND_BITS-1:0] a_mask;
    logic [OPND_BITS-1:0] b_mask;
    a_mask = ~({OPND_BITS{1'b1}} << len);
    b_mask = {OPND_BITS{1'b1}} >> len;
    return FRAME_BITS'(len)
         | (FRAME_BITS'(a & a_mask) << LEN_BITS)
         | (FRAME_BITS'(b & b_mask) << (32'(len) + 32'(LEN_BITS)));
  endfunction

endpackage

// File: rtl/mult_sched_if.sv
// rtl/mult_sched_if.sv - requester, multiplier and response signals of mult_sched
interface mult_sched_if
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*LEN_BITS-1:0]  req_len;
  logic [NREQ*OPND_BITS-1:0] req_a;
  logic [NREQ*OPND_BITS-1:0] req_b;

  logic                      mul_ctrl;
  logic                      mul_ser;
  logic                      mul_done;
  logic [FRAME_BITS-1:0]     mul_result;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [2:0]                rsp_id;
  logic [FRAME_BITS-1:0]     rsp_data;
  logic                      rsp_err;

  // Scheduler side.
  modport master (
    input  req_valid, req_len, req_a, req_b, mul_done, mul_result, rsp_ready,
    output req_ready, mul_ctrl, mul_ser, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  // Requesters, multiplier and response consumer.
  modport slave (
    output req_valid, req_len, req_a, req_b, mul_done, mul_result, rsp_ready,
    input  req_ready, mul_ctrl, mul_ser, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// rtl/mult_sched_rr_arbiter.sv - round-robin arbiter owning the next-search pointer
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic            update,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_id
);
  logic [2:0] ptr;
  logic       found;

  // First active request at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (enable && !found && req[j] && (((int'(ptr) + i) % NREQ) == j)) begin
          grant[j] = 1'b1;
          grant_id = 3'(j);
          found    = 1'b1;
        end
      end
    end
  end

  // Search restarts just past the requester that was last accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 3'd0;
    end else if (update) begin
      ptr <= (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
    end
  end

endmodule

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - serial multiplier scheduler; MULT_SCHED_TIMEOUT_EN adds the WAIT watchdog
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4
`ifdef MULT_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic         clk,
  input  logic         rst,
  mult_sched_if.master bus
);
  state_t                 state;
  logic [NREQ-1:0]        grant;
  logic [2:0]             grant_id;
  logic                   arb_enable;
  logic                   accept;
  logic [LEN_BITS-1:0]    sel_len;
  logic [OPND_BITS-1:0]   sel_a;
  logic [OPND_BITS-1:0]   sel_b;
  logic [2:0]             job_id;
  logic [LEN_BITS-1:0]    job_len;
  logic [OPND_BITS-1:0]   job_a;
  logic [OPND_BITS-1:0]   job_b;
  logic [FRAME_BITS-1:0]  frame;
  logic [FRAME_BITS-1:0]  shreg;
  logic [5:0]             bit_cnt;
`ifdef MULT_SCHED_TIMEOUT_EN
  logic [7:0]             wdog;
`endif

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_enable    = (state == ST_IDLE) && !rst;
  assign accept        = |grant;
  assign bus.req_ready = grant;

  assign sel_len = bus.req_len[int'(grant_id)*LEN_BITS +: LEN_BITS];
  assign sel_a   = bus.req_a[int'(grant_id)*OPND_BITS +: OPND_BITS];
  assign sel_b   = bus.req_b[int'(grant_id)*OPND_BITS +: OPND_BITS];
  assign frame   = build_frame(job_len, job_a, job_b);

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.req_valid),
    .enable   (arb_enable),
    .update   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Job sequencing: accept, start pulse, 32-bit serial shift, wait for result, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bus.mul_ctrl  <= 1'b0;
      bus.mul_ser   <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 3'd0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      job_id        <= 3'd0;
      job_len       <= '0;
      job_a         <= '0;
      job_b         <= '0;
      shreg         <= '0;
      bit_cnt       <= 6'd0;
`ifdef MULT_SCHED_TIMEOUT_EN
      wdog          <= 8'd0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            job_id  <= grant_id;
            job_len <= sel_len;
            job_a   <= sel_a;
            job_b   <= sel_b;
            if (len_legal(sel_len)) begin
              bus.mul_ctrl <= 1'b1;
              state        <= ST_START;
            end else begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
              bus.rsp_id    <= grant_id;
              state         <= ST_RESP;
            end
          end
        end
        ST_START: begin
          bus.mul_ctrl <= 1'b0;
          bus.mul_ser  <= frame[0];
          shreg        <= frame >> 1;
          bit_cnt      <= 6'd0;
          state        <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_cnt == 6'(FRAME_BITS - 1)) begin
            bus.mul_ser <= 1'b0;
            state       <= ST_WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
            wdog        <= 8'd0;
`endif
          end else begin
            bus.mul_ser <= shreg[0];
            shreg       <= shreg >> 1;
            bit_cnt     <= bit_cnt + 6'd1;
          end
        end
        ST_WAIT: begin
          if (bus.mul_done) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= bus.mul_result;
            bus.rsp_id    <= job_id;
            state         <= ST_RESP;
          end
`ifdef MULT_SCHED_TIMEOUT_EN
          else if (wdog == 8'(TIMEOUT - 1)) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_data  <= '0;
            bus.rsp_id    <= job_id;
            state         <= ST_RESP;
          end else begin
            wdog <= wdog + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
